// File: rtl/sdp_rdma_rd_arb.sv
// Round-robin arbiter for the three SDP read-DMA requesters (BS/BN/EW), with per-requester credit limits.
// Latency: 1 cycle from request accept to dma_rd_req_pvld; the output register accepts a new request every cycle while the DMA is ready.
// Optional macro NVDLA_SDP_RDMA_ARB_WRR_EN adds cfg_wt, giving weighted bursts per requester.
module sdp_rdma_rd_arb #(
    parameter int PD_W       = 79,
    parameter int CREDIT_MAX = 8,
    parameter int CNT_W      = 4
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
`ifdef NVDLA_SDP_RDMA_ARB_WRR_EN
    input  logic [11:0]         cfg_wt,
`endif
    input  logic [2:0]          req_en,
    input  logic [2:0]          req_pvld,
    output logic [2:0]          req_prdy,
    input  logic [3*PD_W-1:0]   req_pd,
    input  logic [2:0]          rsp_done,
    output logic                dma_rd_req_pvld,
    input  logic                dma_rd_req_prdy,
    output logic [PD_W-1:0]     dma_rd_req_pd,
    output logic [1:0]          dma_rd_req_src,
    output logic                arb_idle,
    output logic                arb_err
);

    function automatic logic [1:0] nxt3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [1:0]       rr_q, rr_d;
    logic             vld_q, vld_d;
    logic [PD_W-1:0]  pd_q, pd_d;
    logic [1:0]       src_q, src_d;
    logic             idle_q, idle_d;
    logic             err_q, err_d;

    logic [2:0]       elig;
    logic [2:0]       grant;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;
    logic             found;
    logic             out_rdy;
    logic             accept;

`ifdef NVDLA_SDP_RDMA_ARB_WRR_EN
    logic [3:0]       burst_q, burst_d;
    logic [3:0]       wt_sel;
    logic [4:0]       burst_new;
`endif

    // Grant scan starts at rr_q; payload never feeds this path.
    always_comb begin
        out_rdy = !vld_q | dma_rd_req_prdy;
        grant   = 3'b000;
        gnt_idx = 2'd0;
        found   = 1'b0;
        cand    = rr_q;
        for (int i = 0; i < 3; i++) begin
            elig[i] = req_pvld[i] & req_en[i] & (cnt_q[i] < CNT_W'(CREDIT_MAX));
        end
        for (int k = 0; k < 3; k++) begin
            if (!found && elig[cand]) begin
                found       = 1'b1;
                gnt_idx     = cand;
                grant[cand] = 1'b1;
            end
            cand = nxt3(cand);
        end
        accept   = found & out_rdy;
        req_prdy = grant & {3{out_rdy}};
    end

    always_comb begin
        rr_d = rr_q;
`ifdef NVDLA_SDP_RDMA_ARB_WRR_EN
        burst_d   = burst_q;
        wt_sel    = cfg_wt[gnt_idx*4 +: 4];
        burst_new = (gnt_idx == rr_q) ? {1'b0, burst_q} + 5'd1 : 5'd1;
        // Hold the pointer on the winner until it has used wt+1 accepts.
        if (accept) begin
            if (burst_new >= {1'b0, wt_sel} + 5'd1) begin
                rr_d    = nxt3(gnt_idx);
                burst_d = 4'd0;
            end else begin
                rr_d    = gnt_idx;
                burst_d = burst_new[3:0];
            end
        end
`else
        if (accept) begin
            rr_d = nxt3(gnt_idx);
        end
`endif
    end

    always_comb begin
        vld_d = vld_q;
        pd_d  = pd_q;
        src_d = src_q;
        err_d = err_q;
        if (accept) begin
            vld_d = 1'b1;
            pd_d  = req_pd[gnt_idx*PD_W +: PD_W];
            src_d = gnt_idx;
        end else if (dma_rd_req_prdy) begin
            vld_d = 1'b0;
        end
        // A release against an empty counter is a protocol error, never an underflow.
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (rsp_done[i] && (cnt_q[i] == '0)) begin
                err_d = 1'b1;
            end else if (rsp_done[i] && !(accept && grant[i])) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else if (!rsp_done[i] && accept && grant[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        idle_d = (cnt_d[0] == '0) && (cnt_d[1] == '0) && (cnt_d[2] == '0) && !vld_d;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            rr_q   <= 2'd0;
            vld_q  <= 1'b0;
            pd_q   <= '0;
            src_q  <= 2'd0;
            idle_q <= 1'b1;
            err_q  <= 1'b0;
`ifdef NVDLA_SDP_RDMA_ARB_WRR_EN
            burst_q <= 4'd0;
`endif
        end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            rr_q   <= rr_d;
            vld_q  <= vld_d;
            pd_q   <= pd_d;
            src_q  <= src_d;
            idle_q <= idle_d;
            err_q  <= err_d;
`ifdef NVDLA_SDP_RDMA_ARB_WRR_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign dma_rd_req_pvld = vld_q;
    assign dma_rd_req_pd   = pd_q;
    assign dma_rd_req_src  = src_q;
    assign arb_idle        = idle_q;
    assign arb_err         = err_q;

endmodule
